// File: rtl/dac_frame_if.sv
// Sample stream into the DAC frame serializer: x/y/z samples with a valid/ready handshake.
interface dac_frame_if;
  logic signed [13:0] x_in;
  logic signed [13:0] y_in;
  logic signed [13:0] z_in;
  logic               in_valid;
  logic               in_ready;

  modport master (
    output x_in, y_in, z_in, in_valid,
    input  in_ready
  );

  modport slave (
    input  x_in, y_in, z_in, in_valid,
    output in_ready
  );
endinterface

// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer: holds one x/y/z sample in a skid buffer and plays the active sample out
// as interleaved frames on two dual-channel DACs (DAC1: x/y, DAC2: z/midscale).
module dac_frame_serializer #(
  parameter int DIV        = 4,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dac_frame_if.slave  smp,
  output logic [13:0] dac1_d,
  output logic [13:0] dac2_d,
  output logic        daclk_1,
  output logic        daclk_2,
  output logic        ws_1,
  output logic        ws_2,
  output logic        frame_done,
  output logic [15:0] underrun
);

  localparam int DATA_W = 14;
  localparam int CNT_W  = $clog2(2 * DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2 * DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV);
  localparam logic [DATA_W-1:0] MIDSCALE = OFFSET_BIN ? 14'h2000 : 14'h0000;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SLOT_A = 2'd1;
  localparam logic [1:0] SLOT_B = 2'd2;

  // Two's complement to DAC code; offset binary only flips the sign bit.
  function automatic logic [DATA_W-1:0] conv(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (OFFSET_BIN) begin
      r[DATA_W-1] = ~v[DATA_W-1];
    end
    return r;
  endfunction

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic                      buf_full;
  logic signed [DATA_W-1:0]  buf_x_p0;
  logic signed [DATA_W-1:0]  buf_y_p0;
  logic signed [DATA_W-1:0]  buf_z_p0;
  logic signed [DATA_W-1:0]  act_x_p1;
  logic signed [DATA_W-1:0]  act_y_p1;
  logic signed [DATA_W-1:0]  act_z_p1;

  logic slot_end;
  logic frame_end;
  logic accept;
  logic load;

  assign slot_end     = (cnt == CNT_LAST);
  assign frame_end    = (state == SLOT_B) && slot_end;
  assign accept       = smp.in_valid && !buf_full;
  // The buffer drains into the active registers on start-up and at every frame boundary.
  assign load         = buf_full && ((state == IDLE) || frame_end);
  assign smp.in_ready = ~buf_full;

  // Stage 0: single-entry input buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full <= 1'b0;
      buf_x_p0 <= '0;
      buf_y_p0 <= '0;
      buf_z_p0 <= '0;
    end else begin
      if (accept) begin
        buf_x_p0 <= smp.x_in;
        buf_y_p0 <= smp.y_in;
        buf_z_p0 <= smp.z_in;
      end
      buf_full <= accept || (buf_full && !load);
    end
  end

  // Stage 1: active sample, held for a whole frame and repeated when the buffer is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_x_p1 <= '0;
      act_y_p1 <= '0;
      act_z_p1 <= '0;
    end else if (load) begin
      act_x_p1 <= buf_x_p0;
      act_y_p1 <= buf_y_p0;
      act_z_p1 <= buf_z_p0;
    end
  end

  // Slot sequencer: IDLE waits for the first sample, then SLOT_A/SLOT_B alternate forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (buf_full) state <= SLOT_A;
        end
        SLOT_A: begin
          if (slot_end) begin
            state <= SLOT_B;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SLOT_B: begin
          if (slot_end) begin
            state <= SLOT_A;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Underrun counter: a frame boundary with nothing buffered repeats the old sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= '0;
    end else if (frame_end && !buf_full && (underrun != 16'hFFFF)) begin
      underrun <= underrun + 16'd1;
    end
  end

  // Stage 2: registered DAC bus, word select and write clock; daclk rises mid-slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dac1_d     <= MIDSCALE;
      dac2_d     <= MIDSCALE;
      daclk_1    <= 1'b0;
      daclk_2    <= 1'b0;
      ws_1       <= 1'b0;
      ws_2       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      case (state)
        SLOT_A: begin
          dac1_d  <= conv(act_x_p1);
          dac2_d  <= conv(act_z_p1);
          ws_1    <= 1'b1;
          ws_2    <= 1'b1;
          daclk_1 <= (cnt >= CNT_HALF);
          daclk_2 <= (cnt >= CNT_HALF);
        end
        SLOT_B: begin
          dac1_d  <= conv(act_y_p1);
          dac2_d  <= MIDSCALE;
          ws_1    <= 1'b0;
          ws_2    <= 1'b0;
          daclk_1 <= (cnt >= CNT_HALF);
          daclk_2 <= (cnt >= CNT_HALF);
        end
        default: begin
          dac1_d  <= conv(act_x_p1);
          dac2_d  <= conv(act_z_p1);
          ws_1    <= 1'b0;
          ws_2    <= 1'b0;
          daclk_1 <= 1'b0;
          daclk_2 <= 1'b0;
        end
      endcase
    end
  end

endmodule
